meteor_spawn_scheduler: RTL and testbench

Sequences meteorite spawning for the game datapath. It counts frame ticks and, when a spawn is due, picks the lowest-indexed free meteor slot. It then serially harvests 16 bits from the shared ring-oscillator random bit source and issues one spawn command (slot, x position, speeds, direction sign) over a valid/ready handshake to the meteor motion logic. It is the only consumer of the random bit stream, so random bits are never shared mid-word.

---
 rtl/meteor_spawn_scheduler.sv | 172 +++++++++++++++++
 tb/tb_meteor_spawn_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meteor_spawn_scheduler.sv
// ============================================================================
// Module   : meteor_spawn_scheduler
// Purpose  : Frame-tick paced meteor spawner; picks the lowest free slot, harvests
//            16 random bits and offers one spawn command over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module meteor_spawn_scheduler #(
    parameter int NUM_SLOTS      = 8,
    parameter int SPAWN_INTERVAL = 30,
    parameter int SCREEN_W       = 640
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_Clk,
    input  logic                 enable,
    input  logic                 rand_bit,
    input  logic [NUM_SLOTS-1:0] slot_busy,
    input  logic                 spawn_ready,
    output logic                 spawn_valid,
    output logic [3:0]           spawn_slot,
    output logic [9:0]           spawn_x,
    output logic [2:0]           spawn_x_speed,
    output logic [2:0]           spawn_y_speed,
    output logic                 spawn_sign,
    output logic [7:0]           spawn_count,
    output logic                 pending
);

    localparam logic [7:0] c_INTERVAL = 8'(SPAWN_INTERVAL);
    localparam logic [9:0] c_SCREEN_W = 10'(SCREEN_W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIND   = 2'd1,
        S_GATHER = 2'd2,
        S_OFFER  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_fs1, r_fs2, r_fs3;
    logic        r_tick;
    logic        r_parity;
    logic [7:0]  r_countdown;
    logic [3:0]  r_gcnt;
    logic [15:0] r_word;
    logic        r_valid;
    logic [3:0]  r_slot;
    logic [9:0]  r_x;
    logic [2:0]  r_xs, r_ys;
    logic        r_sign;
    logic [7:0]  r_count;
    logic        r_pending;

    logic        w_free_any;
    logic [3:0]  w_free_idx;
    logic [15:0] w_word_full;
    logic [9:0]  w_raw;
    logic [9:0]  w_x;

    // Scan downward so the last hit is the lowest free index.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = 4'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) begin
                w_free_any = 1'b1;
                w_free_idx = 4'(i);
            end
        end
    end

    assign w_word_full = {rand_bit, r_word[15:1]};
    assign w_raw       = w_word_full[9:0];
    assign w_x         = (w_raw >= c_SCREEN_W) ? (w_raw - c_SCREEN_W) : w_raw;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_fs1    <= 1'b0;
            r_fs2    <= 1'b0;
            r_fs3    <= 1'b0;
            r_tick   <= 1'b0;
            r_parity <= 1'b0;
        end else begin
            r_fs1  <= frame_Clk;
            r_fs2  <= r_fs1;
            r_fs3  <= r_fs2;
            r_tick <= r_fs2 & ~r_fs3;
            if (r_tick) begin
                r_parity <= ~r_parity;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_countdown <= c_INTERVAL;
            r_gcnt      <= 4'd0;
            r_word      <= 16'd0;
            r_valid     <= 1'b0;
            r_slot      <= 4'd0;
            r_x         <= 10'd0;
            r_xs        <= 3'd0;
            r_ys        <= 3'd0;
            r_sign      <= 1'b0;
            r_count     <= 8'd0;
            r_pending   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_tick && enable) begin
                        if (r_countdown > 8'd1) begin
                            r_countdown <= r_countdown - 8'd1;
                        end else begin
                            r_state <= S_FIND;
                        end
                    end
                end
                S_FIND: begin
                    if (w_free_any) begin
                        r_slot      <= w_free_idx;
                        r_countdown <= c_INTERVAL;
                        r_pending   <= 1'b0;
                        r_gcnt      <= 4'd0;
                        r_state     <= S_GATHER;
                    end else begin
                        // Parked at 1 so the very next enabled tick retries.
                        r_pending   <= 1'b1;
                        r_countdown <= 8'd1;
                        r_state     <= S_IDLE;
                    end
                end
                S_GATHER: begin
                    r_word <= w_word_full;
                    r_gcnt <= r_gcnt + 4'd1;
                    if (r_gcnt == 4'd15) begin
                        r_x     <= w_x;
                        r_xs    <= (w_word_full[12:10] == 3'd0) ? 3'd1 : w_word_full[12:10];
                        r_ys    <= (w_word_full[15:13] == 3'd0) ? 3'd1 : w_word_full[15:13];
                        r_sign  <= r_parity;
                        r_valid <= 1'b1;
                        r_state <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (spawn_ready) begin
                        r_valid <= 1'b0;
                        if (r_count != 8'hFF) begin
                            r_count <= r_count + 8'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign spawn_valid   = r_valid;
    assign spawn_slot    = r_slot;
    assign spawn_x       = r_x;
    assign spawn_x_speed = r_xs;
    assign spawn_y_speed = r_ys;
    assign spawn_sign    = r_sign;
    assign spawn_count   = r_count;
    assign pending       = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_meteor_spawn_scheduler.sv
// ============================================================================
// Module   : tb_meteor_spawn_scheduler
// Purpose  : Randomized bench for meteor_spawn_scheduler against a timeline
//            reference model of the spawn schedule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_meteor_spawn_scheduler;

    localparam int c_INTERVAL = 3;
    localparam int c_SCREEN_W = 640;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_Clk;
    logic       enable;
    logic       rand_bit;
    logic [7:0] slot_busy;
    logic       spawn_ready;
    logic       spawn_valid;
    logic [3:0] spawn_slot;
    logic [9:0] spawn_x;
    logic [2:0] spawn_x_speed;
    logic [2:0] spawn_y_speed;
    logic       spawn_sign;
    logic [7:0] spawn_count;
    logic       pending;

    meteor_spawn_scheduler #(
        .NUM_SLOTS      (8),
        .SPAWN_INTERVAL (c_INTERVAL),
        .SCREEN_W       (c_SCREEN_W)
    ) u_dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_Clk     (frame_Clk),
        .enable        (enable),
        .rand_bit      (rand_bit),
        .slot_busy     (slot_busy),
        .spawn_ready   (spawn_ready),
        .spawn_valid   (spawn_valid),
        .spawn_slot    (spawn_slot),
        .spawn_x       (spawn_x),
        .spawn_x_speed (spawn_x_speed),
        .spawn_y_speed (spawn_y_speed),
        .spawn_sign    (spawn_sign),
        .spawn_count   (spawn_count),
        .pending       (pending)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stimulus controls
    logic        d_enable, d_ready;
    logic [7:0]  d_busy;
    logic        force_en;
    logic [15:0] force_word;
    int          fr_half, fr_cnt;

    // Reference model: timeline of the spawn in flight
    int          cyc;
    logic [4:0]  fh;
    logic        m_busy;
    int          m_find, m_offer;
    int          m_left;
    logic        m_pending;
    int          m_count;
    logic [3:0]  m_slot;
    logic [15:0] m_word;
    logic        m_sign;
    logic        m_par;
    int          tick_total, hs_since_rst;

    // Captured at handshakes / valid rise
    int          dut_rise, last_rise, last_trig;
    logic        prev_v;
    logic [3:0]  last_slot;
    logic [9:0]  last_x;
    logic [2:0]  last_xs, last_ys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_find = -100; m_offer = -100;
        m_left = c_INTERVAL; m_pending = 1'b0; m_count = 0;
        m_slot = 4'd0; m_word = 16'd0; m_sign = 1'b0; m_par = 1'b0;
        fh = 5'd0; fr_cnt = 0; hs_since_rst = 0; prev_v = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, spawn_valid, 0);
        check({tag, "_slot"}, spawn_slot, 0);
        check({tag, "_x"}, spawn_x, 0);
        check({tag, "_xs"}, spawn_x_speed, 0);
        check({tag, "_ys"}, spawn_y_speed, 0);
        check({tag, "_sign"}, spawn_sign, 0);
        check({tag, "_count"}, spawn_count, 0);
        check({tag, "_pending"}, pending, 0);
    endtask

    task automatic step();
        logic       exp_v, tick, found;
        logic [9:0] raw, ex;
        logic [2:0] exs, eys;
        int         idx;
        @(negedge Clk);
        exp_v = m_busy && (cyc >= m_offer);
        check("valid", spawn_valid, exp_v);
        check("count", spawn_count, m_count);
        check("pending", pending, m_pending);
        if (exp_v) begin
            raw = m_word[9:0];
            ex  = (raw >= 10'(c_SCREEN_W)) ? raw - 10'(c_SCREEN_W) : raw;
            exs = (m_word[12:10] == 3'd0) ? 3'd1 : m_word[12:10];
            eys = (m_word[15:13] == 3'd0) ? 3'd1 : m_word[15:13];
            check("slot", spawn_slot, m_slot);
            check("x", spawn_x, ex);
            check("xspeed", spawn_x_speed, exs);
            check("yspeed", spawn_y_speed, eys);
            check("sign", spawn_sign, m_sign);
        end
        if (spawn_valid && !prev_v) dut_rise = cyc;
        prev_v = spawn_valid;

        fr_cnt++;
        if (fr_cnt >= fr_half) begin
            fr_cnt = 0;
            frame_Clk = ~frame_Clk;
        end
        if (force_en && m_busy && cyc > m_find && cyc <= m_find + 16)
            rand_bit = force_word[cyc - m_find - 1];
        else
            rand_bit = 1'($urandom);
        enable      = d_enable;
        spawn_ready = d_ready;
        slot_busy   = d_busy;

        // A frame rise driven in cycle d shows up as a tick in cycle d+3.
        fh   = {fh[3:0], frame_Clk};
        tick = fh[3] & ~fh[4];
        if (m_busy) begin
            if (cyc == m_find) begin
                found = 1'b0; idx = 0;
                for (int i = 0; i < 8; i++) begin
                    if (!found && !slot_busy[i]) begin
                        found = 1'b1; idx = i;
                    end
                end
                if (found) begin
                    m_slot = 4'(idx); m_pending = 1'b0; m_left = c_INTERVAL;
                end else begin
                    m_pending = 1'b1; m_busy = 1'b0; m_left = 1;
                end
            end else if (cyc > m_find && cyc <= m_find + 16) begin
                m_word[cyc - m_find - 1] = rand_bit;
            end
            if (m_busy && cyc == m_offer - 1) m_sign = m_par;
            if (exp_v && spawn_ready) begin
                m_busy = 1'b0;
                if (m_count != 255) m_count++;
                hs_since_rst++;
                last_slot = spawn_slot; last_x = spawn_x;
                last_xs = spawn_x_speed; last_ys = spawn_y_speed;
                last_rise = dut_rise; last_trig = m_find - 1;
            end
        end else if (tick && enable) begin
            if (m_left > 1) m_left--;
            else begin
                m_busy = 1'b1; m_find = cyc + 1; m_offer = cyc + 18;
            end
        end
        m_par = m_par ^ tick;
        tick_total += int'(tick);
        cyc++;
    endtask

    task automatic run_until_hs(input int n, input int bound);
        int target, k;
        target = hs_since_rst + n;
        k = 0;
        while (hs_since_rst < target && k < bound) begin
            step();
            k++;
        end
        check("hs_timeout", hs_since_rst, target);
    endtask

    initial begin
        int k, t0, hs0;
        Reset = 1'b1; frame_Clk = 1'b0; enable = 1'b0; rand_bit = 1'b0;
        slot_busy = 8'd0; spawn_ready = 1'b0;
        d_enable = 1'b1; d_ready = 1'b1; d_busy = 8'd0;
        force_en = 1'b0; force_word = 16'd0; fr_half = 2;
        cyc = 0; tick_total = 0; dut_rise = 0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_reset_outputs("rst");
        Reset = 1'b0;

        // First spawn: slot 0, 18 cycles after the triggering tick
        run_until_hs(1, 200);
        check("first_slot", last_slot, 0);
        check("first_latency", last_rise - last_trig, 18);
        step();
        check("first_count", spawn_count, 1);

        // Directed random words
        force_en = 1'b1; force_word = 16'h8BFF;
        run_until_hs(1, 200);
        check("x_8BFF", last_x, 383);
        check("xs_8BFF", last_xs, 2);
        check("ys_8BFF", last_ys, 4);
        force_word = 16'h0000;
        run_until_hs(1, 200);
        check("x_0000", last_x, 0);
        check("xs_0000", last_xs, 1);
        check("ys_0000", last_ys, 1);
        force_en = 1'b0;

        // Lowest free slot
        d_busy = 8'b0000_0111;
        run_until_hs(1, 200);
        check("slot_07", last_slot, 3);

        // No free slot -> pending, then slot 5 frees up
        d_busy = 8'hFF;
        k = 0;
        while (!m_pending && k < 200) begin step(); k++; end
        step();
        check("pend_set", pending, 1);
        repeat (10) step();
        check("pend_novalid", spawn_valid, 0);
        d_busy = 8'hDF;
        run_until_hs(1, 200);
        check("slot_5", last_slot, 5);
        step();
        check("pend_clr", pending, 0);

        // Backpressure: fields must hold for 50 cycles
        d_busy = 8'h00; d_ready = 1'b0;
        k = 0;
        while (!(m_busy && cyc >= m_offer) && k < 200) begin step(); k++; end
        repeat (50) step();
        check("stall_valid", spawn_valid, 1);
        d_ready = 1'b1;
        hs0 = hs_since_rst;
        run_until_hs(1, 10);
        repeat (3) step();
        check("stall_one_hs", hs_since_rst - hs0, 1);

        // Asynchronous reset mid-gather
        k = 0;
        while (!(m_busy && cyc == m_find + 6) && k < 200) begin step(); k++; end
        check("gather_reached", cyc, m_find + 6);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("async");
        frame_Clk = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        model_reset();
        Reset = 1'b0;

        // Enable gap of 10 ticks freezes the countdown
        d_enable = 1'b0;
        t0 = tick_total;
        k = 0;
        while (tick_total - t0 < 10 && k < 300) begin step(); k++; end
        check("gap_ticks", tick_total - t0, 10);
        check("gap_no_hs", hs_since_rst, 0);
        d_enable = 1'b1;
        run_until_hs(1, 200);

        // Random traffic until the counter saturates
        k = 0;
        while (hs_since_rst < 300 && k < 40000) begin
            d_ready  = ($urandom_range(0, 2) != 0);
            d_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) d_busy = 8'hFF;
            else d_busy = 8'($urandom) & 8'($urandom);
            step();
            k++;
        end
        check("rand_hs", hs_since_rst >= 300, 1);
        d_ready = 1'b1;
        repeat (30) step();
        check("saturated", spawn_count, 255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
